// File: rtl/conv_viterbi_codec_pkg.sv
// Shared types and code definition for the rate-1/2, K=3 convolutional codec.
// Metrics live in an 8-bit container; METRIC_W of 3..7 is supported.
package conv_codec_pkg;

  localparam logic [2:0] G0 = 3'b111;
  localparam logic [2:0] G1 = 3'b101;

  localparam int unsigned NUM_STATES = 4;
  localparam int unsigned METRIC_CONTAINER_W = 8;

  // Encoder/trellis state {s1, s0} = {b[k-1], b[k-2]}
  typedef logic [1:0] state_t;
  typedef logic [METRIC_CONTAINER_W-1:0] metric_t;

  localparam metric_t METRIC_INIT = 8'd4;

  typedef enum logic {
    PHASE0,
    PHASE1
  } phase_t;

  typedef enum logic [1:0] {
    DEC_PRIME,
    DEC_SYM0,
    DEC_SYM1
  } dec_state_t;

  // Returns {c0, c1} for information bit b leaving state s
  function automatic logic [1:0] expected_symbol(state_t s, logic b);
    logic [2:0] taps;
    taps = {b, s};
    return {^(taps & G0), ^(taps & G1)};
  endfunction

  function automatic logic [1:0] branch_dist(logic [1:0] a, logic [1:0] b);
    logic [1:0] x;
    x = a ^ b;
    return {1'b0, x[1]} + {1'b0, x[0]};
  endfunction

endpackage

// File: rtl/conv_viterbi_codec_if.sv
// Codec signal bundle: information/channel side and decoder results.
interface conv_viterbi_codec_if;
  logic info;
  logic code;
  logic code_in;
  logic decoded;
  logic valid;
  logic error;

  modport master (
    output info,
    output code_in,
    input  code,
    input  decoded,
    input  valid,
    input  error
  );

  modport slave (
    input  info,
    input  code_in,
    output code,
    output decoded,
    output valid,
    output error
  );
endinterface

// File: rtl/conv_encoder.sv
// Rate-1/2 K=3 encoder; emits c0 then c1 on alternate clocks.
module conv_encoder
  import conv_codec_pkg::*;
(
  input logic Clock,
  input logic reset,
  conv_viterbi_codec_if.slave bus
);

  phase_t     phase, phase_next;
  state_t     state, state_next;
  logic       parity, parity_next;
  logic       code, code_next;
  logic [1:0] sym;

  assign sym      = expected_symbol(state, bus.info);
  assign bus.code = code;

  always_ff @(posedge Clock or negedge reset) begin
    if (!reset) begin
      phase  <= PHASE0;
      state  <= '0;
      parity <= 1'b0;
      code   <= 1'b0;
    end else begin
      phase  <= phase_next;
      state  <= state_next;
      parity <= parity_next;
      code   <= code_next;
    end
  end

  always_comb begin
    phase_next  = phase;
    state_next  = state;
    parity_next = parity;
    code_next   = code;
    case (phase)
      PHASE0: begin
        code_next   = sym[1];
        parity_next = sym[0];
        state_next  = {bus.info, state[1]};
        phase_next  = PHASE1;
      end
      default: begin
        code_next  = parity;
        phase_next = PHASE0;
      end
    endcase
  end

endmodule

// File: rtl/viterbi_decoder.sv
// Hard-decision 4-state Viterbi decoder with register-exchange survivors.
// Output bit is the oldest survivor bit of the best state after each ACS.
module viterbi_decoder
  import conv_codec_pkg::*;
#(
  parameter int unsigned TB_DEPTH = 16,
  parameter int unsigned METRIC_W = 4
) (
  input logic Clock,
  input logic reset,
  conv_viterbi_codec_if.slave bus
);

  localparam metric_t    METRIC_MAX = metric_t'((1 << METRIC_W) - 1);
  localparam logic [5:0] LAST_FILL  = 6'(TB_DEPTH - 1);

  dec_state_t          state, state_next;
  logic                capture_r0, do_acs;
  logic                r0;
  logic [5:0]          fill_cnt;
  logic                decoded_q, valid_q, error_q;
  metric_t             metric     [NUM_STATES];
  logic [TB_DEPTH-1:0] surv       [NUM_STATES];
  metric_t             acc_sum    [NUM_STATES];
  metric_t             new_metric [NUM_STATES];
  logic [TB_DEPTH-1:0] new_surv   [NUM_STATES];
  logic [1:0]          rx;
  state_t              pred_a, pred_b;
  metric_t             sum_a, sum_b;
  metric_t             min_sum;
  state_t              min_idx;

  assign bus.decoded = decoded_q;
  assign bus.valid   = valid_q;
  assign bus.error   = error_q;
  assign rx          = {r0, bus.code_in};

  // The prime state absorbs the one-cycle register delay of the encoder output
  always_ff @(posedge Clock or negedge reset) begin
    if (!reset) state <= DEC_PRIME;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    capture_r0 = 1'b0;
    do_acs     = 1'b0;
    case (state)
      DEC_PRIME: state_next = DEC_SYM0;
      DEC_SYM0: begin
        capture_r0 = 1'b1;
        state_next = DEC_SYM1;
      end
      DEC_SYM1: begin
        do_acs     = 1'b1;
        state_next = DEC_SYM0;
      end
      default: state_next = DEC_PRIME;
    endcase
  end

  // Next state i = {b, s1}; predecessors {s1,0} and {s1,1}, tie goes to s0=0
  always_comb begin
    pred_a   = '0;
    pred_b   = '0;
    sum_a    = '0;
    sum_b    = '0;
    acc_sum  = '{default: '0};
    new_surv = '{default: '0};
    for (int unsigned i = 0; i < NUM_STATES; i++) begin
      pred_a = {i[0], 1'b0};
      pred_b = {i[0], 1'b1};
      sum_a  = metric[pred_a] + metric_t'(branch_dist(expected_symbol(pred_a, i[1]), rx));
      sum_b  = metric[pred_b] + metric_t'(branch_dist(expected_symbol(pred_b, i[1]), rx));
      if (sum_b < sum_a) begin
        acc_sum[i]  = sum_b;
        new_surv[i] = {surv[pred_b][TB_DEPTH-2:0], i[1]};
      end else begin
        acc_sum[i]  = sum_a;
        new_surv[i] = {surv[pred_a][TB_DEPTH-2:0], i[1]};
      end
    end
  end

  always_comb begin
    min_sum    = acc_sum[0];
    min_idx    = '0;
    new_metric = '{default: '0};
    for (int unsigned i = 1; i < NUM_STATES; i++) begin
      if (acc_sum[i] < min_sum) begin
        min_sum = acc_sum[i];
        min_idx = state_t'(i);
      end
    end
    for (int unsigned i = 0; i < NUM_STATES; i++) begin
      new_metric[i] = ((acc_sum[i] - min_sum) > METRIC_MAX) ? METRIC_MAX : (acc_sum[i] - min_sum);
    end
  end

  always_ff @(posedge Clock or negedge reset) begin
    if (!reset) begin
      r0        <= 1'b0;
      fill_cnt  <= '0;
      decoded_q <= 1'b0;
      valid_q   <= 1'b0;
      error_q   <= 1'b0;
      for (int unsigned i = 0; i < NUM_STATES; i++) begin
        metric[i] <= (i == 0) ? '0 : METRIC_INIT;
        surv[i]   <= '0;
      end
    end else begin
      if (capture_r0) r0 <= bus.code_in;
      if (do_acs) begin
        for (int unsigned i = 0; i < NUM_STATES; i++) begin
          metric[i] <= new_metric[i];
          surv[i]   <= new_surv[i];
        end
        decoded_q <= new_surv[min_idx][TB_DEPTH-1];
        error_q   <= (min_sum != '0);
        if (!valid_q) begin
          fill_cnt <= fill_cnt + 6'd1;
          if (fill_cnt == LAST_FILL) valid_q <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/conv_viterbi_codec.sv
// Codec top: encoder and decoder sharing clock and reset; channel loop is external.
module conv_viterbi_codec #(
  parameter int unsigned TB_DEPTH = 16,
  parameter int unsigned METRIC_W = 4
) (
  input  logic Clock,
  input  logic reset,
  input  logic in,
  output logic out,
  input  logic code_in,
  output logic decoded,
  output logic valid,
  output logic error
);

  conv_viterbi_codec_if link ();

  assign link.info    = in;
  assign link.code_in = code_in;
  assign out          = link.code;
  assign decoded      = link.decoded;
  assign valid        = link.valid;
  assign error        = link.error;

  conv_encoder u_encoder (
    .Clock (Clock),
    .reset (reset),
    .bus   (link.slave)
  );

  viterbi_decoder #(
    .TB_DEPTH (TB_DEPTH),
    .METRIC_W (METRIC_W)
  ) u_decoder (
    .Clock (Clock),
    .reset (reset),
    .bus   (link.slave)
  );

endmodule

// File: tb/tb_conv_viterbi_codec.sv
// Directed bench for conv_viterbi_codec with the channel looped back through a flip mask.
module tb_conv_viterbi_codec;

  localparam int DEPTH = 16;
  localparam int LAT   = 2 * DEPTH + 1;  // first edge after release at which decoded carries bit 0

  logic Clock;
  logic reset;
  logic flip;

  conv_viterbi_codec_if tb_bus ();

  assign tb_bus.code_in = tb_bus.code ^ flip;

  conv_viterbi_codec #(
    .TB_DEPTH (DEPTH),
    .METRIC_W (4)
  ) dut (
    .Clock   (Clock),
    .reset   (reset),
    .in      (tb_bus.info),
    .out     (tb_bus.code),
    .code_in (tb_bus.code_in),
    .decoded (tb_bus.decoded),
    .valid   (tb_bus.valid),
    .error   (tb_bus.error)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int   n_checks;
  int   n_fail;
  int   cur_edge;
  logic bits      [0:699];
  logic flip_edge [0:1499];
  int   imp_edge;
  int   skip_lo, skip_hi;
  int   err_lo, err_hi;
  bit   check_err;
  bit   check_out;
  bit   err_seen;

  task automatic check_eq(input string tag, input logic actual, input logic expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s at edge %0d: got %b expected %b", tag, cur_edge, actual, expected);
    end
  endtask

  task automatic check_zero(input string tag);
    check_eq({tag, "_out"},     tb_bus.code,    1'b0);
    check_eq({tag, "_decoded"}, tb_bus.decoded, 1'b0);
    check_eq({tag, "_valid"},   tb_bus.valid,   1'b0);
    check_eq({tag, "_error"},   tb_bus.error,   1'b0);
  endtask

  // Asserts reset at the current time, holds it 3 cycles, releases on a falling edge
  task automatic apply_reset();
    reset       = 1'b0;
    flip        = 1'b0;
    tb_bus.info = 1'b0;
    cur_edge    = -1;
    #1;
    check_zero("rst_async");
    repeat (3) begin
      @(negedge Clock);
      check_zero("rst_hold");
    end
    reset = 1'b1;
  endtask

  task automatic clear_stim();
    foreach (bits[i]) bits[i] = 1'b0;
    foreach (flip_edge[i]) flip_edge[i] = 1'b0;
    imp_edge  = -1000;
    skip_lo   = 1;
    skip_hi   = 0;
    err_lo    = 1;
    err_hi    = 0;
    check_err = 1'b1;
    check_out = 1'b0;
    err_seen  = 1'b0;
  endtask

  task automatic random_bits(input int count);
    for (int i = 0; i < count; i++) bits[i] = 1'($urandom_range(1, 0));
  endtask

  // Edge n counts rising edges after release; bit j is sampled at edge 2j+1
  task automatic run(input int cycles);
    logic exp_dec;
    logic exp_out;
    int   d;
    for (int n = 0; n < cycles; n++) begin
      cur_edge = n;
      exp_dec  = (n >= LAT) ? bits[(n - LAT) / 2] : 1'b0;
      if (!(n >= skip_lo && n <= skip_hi)) check_eq("decoded", tb_bus.decoded, exp_dec);
      check_eq("valid", tb_bus.valid, n >= LAT);
      if (check_err) check_eq("error", tb_bus.error, n >= err_lo && n <= err_hi);
      if (tb_bus.error) err_seen = 1'b1;
      if (check_out) begin
        d       = n - imp_edge;
        exp_out = (d == 0 || d == 1 || d == 2 || d == 4 || d == 5);
        check_eq("out", tb_bus.code, exp_out);
      end
      if (n % 2 == 0) tb_bus.info = bits[n / 2];
      flip = flip_edge[n + 1];
      @(negedge Clock);
    end
    flip = 1'b0;
  endtask

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    cur_edge    = -1;
    reset       = 1'b0;
    flip        = 1'b0;
    tb_bus.info = 1'b0;
    @(negedge Clock);

    // Idle: all-zero data
    clear_stim();
    check_out = 1'b1;
    apply_reset();
    run(80);

    // Impulse: bit 5 (sampled at edge 11) is the only 1
    clear_stim();
    check_out = 1'b1;
    bits[5]   = 1'b1;
    imp_edge  = 11;
    apply_reset();
    run(80);

    // Random loopback, clean channel
    clear_stim();
    random_bits(500);
    apply_reset();
    run(2 * 500 + 40);

    // Single flipped r0 in a zero stream: error after edges 101 and 102 only
    clear_stim();
    flip_edge[100] = 1'b1;
    err_lo         = 101;
    err_hi         = 102;
    apply_reset();
    run(200);

    // Burst of 4 flipped code bits; decoded must be correct again once clear of the burst
    clear_stim();
    random_bits(150);
    for (int e = 161; e <= 164; e++) flip_edge[e] = 1'b1;
    skip_lo   = 145;
    skip_hi   = 228;
    check_err = 1'b0;
    apply_reset();
    run(300);
    cur_edge = 300;
    check_eq("burst_err_seen", err_seen, 1'b1);

    // Mid-stream reset just after an encoder phase-0 edge, then impulse again
    clear_stim();
    random_bits(60);
    apply_reset();
    run(81);
    clear_stim();
    check_out = 1'b1;
    bits[5]   = 1'b1;
    imp_edge  = 11;
    apply_reset();
    run(80);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/conv_viterbi_codec.md
Name: conv_viterbi_codec

Overview:
- Rate-1/2, K=3 convolutional encoder and a hard-decision Viterbi decoder packaged as one PRML-style codec block.
- The encoder serialises two code bits per information bit onto a 1-bit channel.
- The decoder deserialises the channel stream, runs 4-state add-compare-select (ACS) with register-exchange survivors, and outputs the decoded bit plus a channel-error flag.
- The channel input is a separate port so a bench can loop it back or inject errors.

Parameters:
- TB_DEPTH, 16: survivor register length in symbols (decode depth); range 4..32.
- METRIC_W, 4: path-metric width; metrics saturate at 2^METRIC_W-1.

Ports:
- Clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- in  in  1  information bit; sampled on phase-0 edges only, i.e. every 2nd clock.
- out  out  1  serial code bit (registered).
- code_in  in  1  channel bit into the decoder; normally tied to out.
- decoded  out  1  decoded information bit (registered).
- valid  out  1  high once decoded carries real data.
- error  out  1  channel-error flag (registered).

Behaviour:
- Reset (reset=0, async): encoder shift state 00; encoder phase 0; out=0.
- Reset also sets: decoder phase 0, prime flag 1; metrics state0=0, states1..3=4; survivors 0; decoded=0, valid=0, error=0.
- A reset asserted mid-stream discards all state immediately.
- Encoder state is s=(b[k-1],b[k-2]).
- Encoder, phase 0 edge:
  - Sample in as b.
  - c0 = b^s1^s0 (G0=7); c1 = b^s0 (G1=5).
  - out <= c0; hold c1 internally; s <= (b,s1); phase <= 1.
- Encoder, phase 1 edge: out <= c1; phase <= 0.
- Decoder, prime: the first edge after reset release only clears the prime flag. This accounts for the one-cycle register delay of out.
- Decoder, phase 0 edge: store code_in as r0.
- Decoder, phase 1 edge: r1 = code_in; perform ACS on symbol (r0,r1).
- ACS branch metric: Hamming distance (0..2) between (r0,r1) and the expected (c0,c1) for each transition.
- ACS next state: ns = (b, s1) with predecessors (s1,0) and (s1,1).
  - Select the lower sum; on a tie pick the predecessor with s0=0.
- Metric normalisation: subtract the minimum new metric from all metrics; saturate at max.
- Survivors: register-exchange. The new survivor is the selected predecessor's survivor shifted, with b appended. Length is TB_DEPTH.
- decoded <= oldest bit of the survivor of the minimum-metric state (tie: lowest state index). Updated only on ACS edges, held otherwise.
- Latency: information bit sampled at edge E appears on decoded at edge E+2*TB_DEPTH.
- valid is set on the TB_DEPTH-th ACS after reset and stays 1 until reset.
- error <= 1 on an ACS edge when the minimum new metric before normalisation is greater than 0. That means no surviving path matches the symbol.
- error is cleared on the next ACS edge if the condition is absent, so it is held for exactly 2 cycles per bad symbol.
- No backpressure or handshake; the channel runs continuously.

Decomposition:
- Package conv_codec_pkg:
  - generator constants G0=3'b111, G1=3'b101
  - state typedef (2 bits)
  - metric typedef
  - function expected_symbol(state, bit)
- Sub-modules:
  - conv_encoder (shift state, phase, out).
  - viterbi_decoder (deserialiser, ACS, survivors, error).
- The top level only wires the two together and shares Clock and reset.

Test Plan:
- Reset/idle, held continuously (not just at the start):
  - Stimulus: reset low 3 cycles, then in=0 constant, code_in=out.
  - Required at every cycle during reset: out=0, decoded=0, valid=0, error=0.
  - Required after release, indefinitely: out=0, decoded=0, error=0; valid rises 2*16 cycles after the first phase-0 edge.
- Impulse:
  - Stimulus: single in=1 then zeros.
  - Required: out sequence from that edge is 1,1,1,0,1,1, then 0s.
  - Required: decoded shows a single 1 exactly 32 cycles after the sampling edge.
- Random loopback:
  - Stimulus: 500 random in bits, code_in=out.
  - Required: decoded equals in delayed by 32 cycles, sampled on ACS edges; error never 1.
- Single-bit channel error:
  - Stimulus: invert code_in for one cycle mid-stream.
  - Required: error high for 2 cycles at the next ACS edge; decoded sequence still error-free.
- Burst error:
  - Stimulus: invert 4 consecutive code bits.
  - Required: error asserted; metrics stay within 0..15 with no wrap; decoding resynchronises within 2*TB_DEPTH cycles after the burst.
- Mid-stream reset:
  - Stimulus: assert reset between a phase-0 and a phase-1 edge.
  - Required: all outputs 0 immediately; after release, phase and prime restart from the reset state and the impulse test passes again.
